// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for Pong that owns both scores and gates the ball engine through serve, rally and game-over phases.
module pong_game_ctrl #(
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int DELAY_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               frame_tick,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               ball_hold,
  output logic               ball_run,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner,
  output logic [1:0]         state
);
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;
  state_t st, st_nx;
  logic [SCORE_W-1:0] sl_nx, sr_nx;
  logic [DELAY_W-1:0] cnt, cnt_nx;
  logic dir_nx, win_nx;
  assign state = st;
  always_comb begin
    st_nx  = st;
    sl_nx  = score_l;
    sr_nx  = score_r;
    cnt_nx = cnt;
    dir_nx = serve_dir;
    win_nx = winner;
    case (st)
      IDLE, OVER: if (start) begin
        st_nx  = SERVE;
        sl_nx  = '0;
        sr_nx  = '0;
        cnt_nx = '0;
        dir_nx = 1'b1;
      end
      SERVE: if (frame_tick) begin
        st_nx  = (cnt == DELAY_W'(SERVE_FRAMES - 1)) ? PLAY : SERVE;
        cnt_nx = (cnt == DELAY_W'(SERVE_FRAMES - 1)) ? '0 : cnt + 1'b1;
      end
      PLAY: begin
        // a simultaneous double miss is a replay: only the phase changes
        if (miss_l || miss_r) begin
          st_nx  = SERVE;
          cnt_nx = '0;
        end
        if (miss_l && !miss_r) begin
          sr_nx  = score_r + 1'b1;
          dir_nx = 1'b0;
          st_nx  = (sr_nx == SCORE_W'(WIN_SCORE)) ? OVER : SERVE;
          win_nx = (sr_nx == SCORE_W'(WIN_SCORE)) ? 1'b1 : winner;
        end
        if (miss_r && !miss_l) begin
          sl_nx  = score_l + 1'b1;
          dir_nx = 1'b1;
          st_nx  = (sl_nx == SCORE_W'(WIN_SCORE)) ? OVER : SERVE;
          win_nx = (sl_nx == SCORE_W'(WIN_SCORE)) ? 1'b0 : winner;
        end
      end
      default: st_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= IDLE;
      score_l   <= '0;
      score_r   <= '0;
      cnt       <= '0;
      serve_dir <= 1'b1;
      winner    <= 1'b0;
      ball_hold <= 1'b1;
      ball_run  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st        <= st_nx;
      score_l   <= sl_nx;
      score_r   <= sr_nx;
      cnt       <= cnt_nx;
      serve_dir <= dir_nx;
      winner    <= win_nx;
      ball_hold <= (st_nx != PLAY);
      ball_run  <= (st_nx == PLAY);
      game_over <= (st_nx == OVER);
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed match scenarios plus random play checked against a point-counting reference model.
module tb_pong_game_ctrl;
  localparam int SF = 3;
  localparam int WIN = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, frame_tick = 1'b0, miss_l = 1'b0, miss_r = 1'b0;
  logic ball_hold, ball_run, serve_dir, game_over, winner;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  int m_phase, m_ls, m_rs, m_ticks, m_dir, m_win;

  pong_game_ctrl #(.SCORE_W(4), .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .DELAY_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_tick(frame_tick),
    .miss_l(miss_l), .miss_r(miss_r), .ball_hold(ball_hold), .ball_run(ball_run),
    .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
    .game_over(game_over), .winner(winner), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ls = 0; m_rs = 0; m_ticks = 0; m_dir = 1; m_win = 0;
  endtask

  // phases: 0 idle, 1 waiting for serve, 2 rally, 3 match decided
  task automatic model_step(input logic s, input logic f, input logic ml, input logic mr);
    if ((m_phase == 0 || m_phase == 3) && s) begin
      m_phase = 1; m_ls = 0; m_rs = 0; m_ticks = 0; m_dir = 1;
    end else if (m_phase == 1 && f) begin
      m_ticks++;
      if (m_ticks == SF) begin m_phase = 2; m_ticks = 0; end
    end else if (m_phase == 2 && (ml || mr)) begin
      m_phase = 1; m_ticks = 0;
      if (ml && !mr) begin
        m_rs++; m_dir = 0;
        if (m_rs == WIN) begin m_phase = 3; m_win = 1; end
      end else if (mr && !ml) begin
        m_ls++; m_dir = 1;
        if (m_ls == WIN) begin m_phase = 3; m_win = 0; end
      end
    end
  endtask

  task automatic full_check(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_phase));
    chk({tag, ".score_l"}, 32'(score_l), 32'(m_ls));
    chk({tag, ".score_r"}, 32'(score_r), 32'(m_rs));
    chk({tag, ".serve_dir"}, 32'(serve_dir), 32'(m_dir));
    chk({tag, ".winner"}, 32'(winner), 32'(m_win));
    chk({tag, ".ball_hold"}, 32'(ball_hold), 32'(m_phase != 2));
    chk({tag, ".ball_run"}, 32'(ball_run), 32'(m_phase == 2));
    chk({tag, ".game_over"}, 32'(game_over), 32'(m_phase == 3));
  endtask

  task automatic step(input string tag, input logic s, input logic f, input logic ml, input logic mr);
    start = s; frame_tick = f; miss_l = ml; miss_r = mr;
    @(posedge clk);
    model_step(s, f, ml, mr);
    #1;
    start = 1'b0; frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    full_check(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step(tag, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int j = 0; j < 9; j++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    full_check(tag);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    full_check("reset");
    reset_n = 1'b1;
    step("idle_tick", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("idle_ignores", 32'(state), 32'd0);
    step("start", 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("serve", SF - 1);
    chk("serve_2ticks", 32'(state), 32'd1);
    ticks("serve", 1);
    chk("play_entered", 32'(state), 32'd2);
    chk("play_run", 32'(ball_run), 32'd1);
    step("miss_r", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("miss_r_score", 32'(score_l), 32'd1);
    chk("miss_r_dir", 32'(serve_dir), 32'd1);
    ticks("reserve", SF - 1);
    chk("reserve_2ticks", 32'(state), 32'd1);
    ticks("reserve", 1);
    chk("replay_play", 32'(state), 32'd2);
    async_reset("async_rst");
    chk("async_rst_hold", 32'(ball_hold), 32'd1);
    step("restart", 1'b1, 1'b0, 1'b0, 1'b0);
    ticks("s4", SF);
    step("both_miss", 1'b0, 1'b1, 1'b1, 1'b1);
    chk("both_state", 32'(state), 32'd1);
    chk("both_scores", 32'({score_l, score_r}), 32'd0);
    ticks("s5a", SF);
    step("miss_l1", 1'b0, 1'b0, 1'b1, 1'b0);
    ticks("s5b", SF);
    step("miss_l2", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("win_state", 32'(state), 32'd3);
    chk("win_who", 32'(winner), 32'd1);
    chk("win_score", 32'(score_r), 32'(WIN));
    step("over_ignore", 1'b0, 1'b1, 1'b1, 1'b0);
    ticks("over_ignore", 2);
    chk("over_frozen", 32'(score_r), 32'(WIN));
    step("over_start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("over_restart", 32'({state, score_l, score_r}), 32'h100);
    chk("winner_held", 32'(winner), 32'd1);
    ticks("s6", SF);
    for (int i = 0; i < 5; i++) step("miss_r_held", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("held_once", 32'(score_l), 32'd1);
    step("serve_start", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("serve_start_ign", 32'({state, score_l}), 32'h11);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 2) async_reset("rnd_rst");
      else step("rnd", $urandom_range(99) < 4, $urandom_range(99) < 30,
                $urandom_range(99) < 6, $urandom_range(99) < 6);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
